// File: rtl/ctc_addr_seq.sv
// CTC ROM address sequencer: 56-state word counter, serial instruction capture,
// next-address selection, status bits, return register and serial address output.
module ctc_addr_seq #(
   parameter int ADR_W    = 8,
   parameter int STAT_W   = 12,
   parameter int IS_START = 45
) (
   input  logic              cph2,
   input  logic              nrst,
   input  logic              is,
   input  logic              carry,
   input  logic              key_valid,
   input  logic [7:0]        key_code,
   output logic              ia,
   output logic              sync,
   output logic [ADR_W-1:0]  adr,
   output logic [STAT_W-1:0] status
);

   localparam int IW = $clog2(ADR_W);
   localparam logic [3:0] OP_SET    = 4'b0001;
   localparam logic [3:0] OP_TEST   = 4'b0101;
   localparam logic [3:0] OP_CLR    = 4'b1001;
   localparam logic [3:0] OP_CLRALL = 4'b1101;
   localparam logic [3:0] OP_RET    = 4'b0110;
   localparam logic [3:0] OP_KEYS   = 4'b1100;

   logic [5:0]        cnt_reg, cnt_next;
   logic [ADR_W-1:0]  adr_reg, adr_next;
   logic [ADR_W-1:0]  rtn_reg, rtn_next;
   logic [STAT_W-1:0] status_reg, status_next;
   logic              cond_reg, cond_next;
   logic              carry_acc_reg, carry_acc_next;
   logic [7:0]        key_r_reg, key_r_next;
   logic [9:0]        is_sr_reg, is_sr_next;

   logic              word_end, in_win, misc;
   logic [3:0]        op, n;
   logic [ADR_W-1:0]  adr_inc, target;
   logic [STAT_W-1:0] set_hit, clr_hit, tst_hit;

   assign word_end = (cnt_reg == 6'd55);
   assign in_win   = (cnt_reg >= 6'(IS_START)) && (cnt_reg <= 6'(IS_START + 9));
   assign op       = is_sr_reg[5:2];
   assign n        = is_sr_reg[9:6];
   assign misc     = word_end && (is_sr_reg[1:0] == 2'b00);
   assign adr_inc  = adr_reg + ADR_W'(1);
   assign target   = ADR_W'(is_sr_reg[9:2]);

   // Per-bit status update; an index beyond STAT_W simply matches no bit.
   genvar gi;
   generate
      for (gi = 0; gi < STAT_W; gi++) begin : g_stat
         assign set_hit[gi] = misc && (op == OP_SET) && (n == 4'(gi));
         assign clr_hit[gi] = misc && (((op == OP_CLR) && (n == 4'(gi))) || (op == OP_CLRALL));
         assign tst_hit[gi] = misc && (op == OP_TEST) && (n == 4'(gi)) && status_reg[gi];
         if (gi == 0) begin : g_key
            assign status_next[gi] = key_valid | set_hit[gi] | (status_reg[gi] & ~clr_hit[gi]);
         end else begin : g_plain
            assign status_next[gi] = set_hit[gi] | (status_reg[gi] & ~clr_hit[gi]);
         end
      end
   endgenerate

   always_comb begin
      adr_next = adr_reg;
      rtn_next = rtn_reg;
      if (word_end) begin
         adr_next = adr_inc;
         case (is_sr_reg[1:0])
            2'b01: begin
               rtn_next = adr_inc;
               adr_next = target;
            end
            2'b11: if (!cond_reg) adr_next = target;
            2'b00: begin
               if (op == OP_RET)
                  adr_next = rtn_reg;
               else if (op == OP_KEYS)
                  adr_next = key_valid ? ADR_W'(key_code) : ADR_W'(key_r_reg);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cnt_next       = word_end ? 6'd0 : cnt_reg + 6'd1;
      cond_next      = word_end ? (carry_acc_reg | (|tst_hit)) : cond_reg;
      carry_acc_next = word_end ? 1'b0 : (carry_acc_reg | carry);
      key_r_next     = key_valid ? key_code : key_r_reg;
      is_sr_next     = in_win ? {is, is_sr_reg[9:1]} : is_sr_reg;
   end

   always_ff @(posedge cph2) begin
      if (!nrst) begin
         cnt_reg       <= '0;
         adr_reg       <= '0;
         rtn_reg       <= '0;
         status_reg    <= '0;
         cond_reg      <= 1'b0;
         carry_acc_reg <= 1'b0;
         key_r_reg     <= '0;
         is_sr_reg     <= '0;
      end else begin
         cnt_reg       <= cnt_next;
         adr_reg       <= adr_next;
         rtn_reg       <= rtn_next;
         status_reg    <= status_next;
         cond_reg      <= cond_next;
         carry_acc_reg <= carry_acc_next;
         key_r_reg     <= key_r_next;
         is_sr_reg     <= is_sr_next;
      end
   end

   // Address goes out LSB first in the first ADR_W states of each word.
   always_comb begin
      ia = 1'b0;
      if (cnt_reg < 6'(ADR_W))
         ia = adr_reg[cnt_reg[IW-1:0]];
   end

   assign sync   = in_win;
   assign adr    = adr_reg;
   assign status = status_reg;

endmodule

// File: tb/tb_ctc_addr_seq.sv
// Directed bench for ctc_addr_seq: one task per feature, word-level stimulus.
module tb_ctc_addr_seq;

   logic        cph2 = 1'b0;
   logic        nrst = 1'b0;
   logic        is = 1'b0;
   logic        carry = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'h00;
   logic        ia;
   logic        sync;
   logic [7:0]  adr;
   logic [11:0] status;

   int errors = 0;
   int checks = 0;

   ctc_addr_seq dut (
      .cph2(cph2), .nrst(nrst), .is(is), .carry(carry),
      .key_valid(key_valid), .key_code(key_code),
      .ia(ia), .sync(sync), .adr(adr), .status(status)
   );

   always #5 cph2 = ~cph2;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   // Runs one 56-state word starting at a negedge in T0; ends at a negedge in the next T0.
   // Collects ia over T0..T7 and counts ia/sync protocol violations.
   task automatic run_word(input logic [9:0] instr, input int carry_ph, input int key_ph,
                           input logic [7:0] kc, output logic [7:0] ia_w, output int bad);
      bad  = 0;
      ia_w = 8'h00;
      for (int c = 0; c < 56; c++) begin
         is        = (c >= 45 && c <= 54) ? instr[c-45] : 1'b0;
         carry     = (c == carry_ph);
         key_valid = (c == key_ph);
         key_code  = (c == key_ph) ? kc : 8'h00;
         #1;
         if (c < 8) ia_w[c] = ia;
         else if (ia !== 1'b0) bad++;
         if (sync !== (c >= 45 && c <= 54)) bad++;
         @(negedge cph2);
      end
      is = 1'b0; carry = 1'b0; key_valid = 1'b0; key_code = 8'h00;
   endtask

   task automatic test_reset();
      logic [7:0] ia_w;
      int bad;
      logic [7:0] exp_ia [3] = '{8'h00, 8'h01, 8'h02};
      logic [7:0] exp_adr[3] = '{8'h01, 8'h02, 8'h03};
      nrst = 1'b0;
      repeat (2) @(negedge cph2);
      nrst = 1'b1;
      #1;
      checks++;
      if (adr !== 8'h00 || status !== 12'h000 || ia !== 1'b0 || sync !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got adr=%h status=%h ia=%b sync=%b want 00 000 0 0", adr, status, ia, sync);
      end
      for (int k = 0; k < 3; k++) begin
         run_word(10'h000, -1, -1, 8'h00, ia_w, bad);
         checks++;
         if (adr !== exp_adr[k] || ia_w !== exp_ia[k] || bad != 0) begin
            errors++;
            $display("FAIL reset_inc word %0d got adr=%h ia=%h bad=%0d want adr=%h ia=%h bad=0",
                     k, adr, ia_w, bad, exp_adr[k], exp_ia[k]);
         end
      end
   endtask

   task automatic test_jsb_return();
      logic [7:0] ia_w;
      int bad;
      logic [9:0] instr  [3] = '{10'h041, 10'h141, 10'h018};
      logic [7:0] exp_adr[3] = '{8'h10, 8'h50, 8'h11};
      logic [7:0] exp_ia [3] = '{8'h03, 8'h10, 8'h50};
      for (int k = 0; k < 3; k++) begin
         run_word(instr[k], -1, -1, 8'h00, ia_w, bad);
         checks++;
         if (adr !== exp_adr[k] || ia_w !== exp_ia[k] || bad != 0) begin
            errors++;
            $display("FAIL jsb_return step %0d got adr=%h ia=%h bad=%0d want adr=%h ia=%h bad=0",
                     k, adr, ia_w, bad, exp_adr[k], exp_ia[k]);
         end
      end
   endtask

   task automatic test_branch();
      logic [7:0] ia_w;
      int bad;
      // nop+carry T12, branch, branch, nop+carry T55, branch, nop+carry T50, branch,
      // jsb FF, nop (wrap), jsb FF, jsb 40 (rtn wraps), return
      logic [9:0] instr  [12] = '{10'h000, 10'h083, 10'h083, 10'h000, 10'h083, 10'h000,
                                  10'h083, 10'h3FD, 10'h000, 10'h3FD, 10'h101, 10'h018};
      int         cph    [12] = '{12, -1, -1, 55, -1, 50, -1, -1, -1, -1, -1, -1};
      logic [7:0] exp_adr[12] = '{8'h12, 8'h13, 8'h20, 8'h21, 8'h20, 8'h21,
                                  8'h22, 8'hFF, 8'h00, 8'hFF, 8'h40, 8'h00};
      for (int k = 0; k < 12; k++) begin
         run_word(instr[k], cph[k], -1, 8'h00, ia_w, bad);
         checks++;
         if (adr !== exp_adr[k] || bad != 0) begin
            errors++;
            $display("FAIL branch step %0d got adr=%h bad=%0d want adr=%h bad=0", k, adr, bad, exp_adr[k]);
         end
      end
   endtask

   task automatic test_status();
      logic [7:0] ia_w;
      int bad;
      // set s5, test s5, branch (not taken), clear s5, test s5, branch (taken), set s13
      logic [9:0]  instr  [7] = '{10'h144, 10'h154, 10'h083, 10'h164, 10'h154, 10'h083, 10'h344};
      logic [7:0]  exp_adr[7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h20, 8'h21};
      logic [11:0] exp_st [7] = '{12'h020, 12'h020, 12'h020, 12'h000, 12'h000, 12'h000, 12'h000};
      for (int k = 0; k < 7; k++) begin
         run_word(instr[k], -1, -1, 8'h00, ia_w, bad);
         checks++;
         if (adr !== exp_adr[k] || status !== exp_st[k] || bad != 0) begin
            errors++;
            $display("FAIL status step %0d got adr=%h status=%h bad=%0d want adr=%h status=%h bad=0",
                     k, adr, status, bad, exp_adr[k], exp_st[k]);
         end
      end
   endtask

   task automatic test_keys();
      logic [7:0] ia_w;
      int bad;
      // key at T10 + nop, keys->rom, set s3, clear-all with key at T55, keys->rom with key at T55
      logic [9:0]  instr  [5] = '{10'h000, 10'h030, 10'h0C4, 10'h034, 10'h030};
      int          kph    [5] = '{10, -1, -1, 55, 55};
      logic [7:0]  kc     [5] = '{8'h3A, 8'h00, 8'h00, 8'h5C, 8'h77};
      logic [7:0]  exp_adr[5] = '{8'h22, 8'h3A, 8'h3B, 8'h3C, 8'h77};
      logic [11:0] exp_st [5] = '{12'h001, 12'h001, 12'h009, 12'h001, 12'h001};
      for (int k = 0; k < 5; k++) begin
         run_word(instr[k], -1, kph[k], kc[k], ia_w, bad);
         checks++;
         if (adr !== exp_adr[k] || status !== exp_st[k] || bad != 0) begin
            errors++;
            $display("FAIL keys step %0d got adr=%h status=%h bad=%0d want adr=%h status=%h bad=0",
                     k, adr, status, bad, exp_adr[k], exp_st[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] ia_w;
      int bad;
      logic [9:0] part = 10'h141;
      for (int c = 0; c < 50; c++) begin
         is = (c >= 45) ? part[c-45] : 1'b0;
         @(negedge cph2);
      end
      nrst = 1'b0;
      is   = part[5];
      @(negedge cph2);
      nrst = 1'b1;
      is   = 1'b0;
      #1;
      checks++;
      if (adr !== 8'h00 || status !== 12'h000 || sync !== 1'b0 || ia !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_state got adr=%h status=%h sync=%b ia=%b want 00 000 0 0", adr, status, sync, ia);
      end
      run_word(10'h0C4, -1, -1, 8'h00, ia_w, bad);
      checks++;
      if (adr !== 8'h01 || status !== 12'h008 || ia_w !== 8'h00 || bad != 0) begin
         errors++;
         $display("FAIL reset_mid_word got adr=%h status=%h ia=%h bad=%0d want adr=01 status=008 ia=00 bad=0",
                  adr, status, ia_w, bad);
      end
   endtask

   initial begin
      test_reset();
      test_jsb_return();
      test_branch();
      test_status();
      test_keys();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
